// File: rtl/sc_fifo_pkg.sv
// rtl/sc_fifo_pkg.sv - shared defaults and busy-state enum for the slow-control FIFO
package sc_fifo_pkg;

  localparam int DEF_DATA_W      = 64;
  localparam int DEF_ADDR_W      = 9;
  localparam int DEF_BUSY_CYCLES = 4;

  typedef enum logic [1:0] {
    BUSY_RESET   = 2'd0,
    BUSY_RECOVER = 2'd1,
    BUSY_READY   = 2'd2
  } busy_state_e;

endpackage

// File: rtl/sc_fifo_ram.sv
// rtl/sc_fifo_ram.sv - simple dual-port storage array, synchronous write, registered read
module sc_fifo_ram #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rd_data;

  // Storage write port; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  // Output register: clears on reset, holds when no read is requested
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_rd_data <= '0;
    else if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/sc_fifo_responder.sv
// rtl/sc_fifo_responder.sv - 64-bit slow-control FIFO with FIFO36-style status; SC_FIFO_FWFT_EN selects first-word-fall-through
module sc_fifo_responder
  import sc_fifo_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int BUSY_CYCLES = DEF_BUSY_CYCLES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] DI,
  input  logic              WREN,
  input  logic              RDEN,
  output logic [DATA_W-1:0] DO,
  output logic              EMPTY,
  output logic              FULL,
  output logic [ADDR_W-1:0] RDCOUNT,
  output logic [ADDR_W-1:0] WRCOUNT,
  output logic              RDBUSY,
  output logic              WRBUSY
);

  localparam logic [ADDR_W:0] LP_FULL_OCC = {1'b1, {ADDR_W{1'b0}}};

  busy_state_e       r_state, w_state_nxt;
  logic [7:0]        r_busy_cnt;
  logic              w_busy;

  logic [ADDR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [ADDR_W:0]   r_occ, w_occ_nxt;
  logic              r_empty, r_full, w_empty_nxt;
  logic              w_wr, w_pop, w_ram_rd;

  // Busy FSM state register plus recovery edge counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= BUSY_RESET;
      r_busy_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state != BUSY_READY) r_busy_cnt <= r_busy_cnt + 8'd1;
    end
  end

  // Busy FSM next state: leave RESET on the first edge, READY after BUSY_CYCLES edges
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      BUSY_RESET:   w_state_nxt = (BUSY_CYCLES <= 1) ? BUSY_READY : BUSY_RECOVER;
      BUSY_RECOVER: if (r_busy_cnt == 8'(BUSY_CYCLES - 1)) w_state_nxt = BUSY_READY;
      default:      w_state_nxt = r_state;
    endcase
  end

  // Busy FSM outputs: both sides recover together
  always_comb begin
    w_busy = (r_state != BUSY_READY);
    RDBUSY = w_busy;
    WRBUSY = w_busy;
  end

  assign w_wr = WREN & ~r_full & ~w_busy;

`ifdef SC_FIFO_FWFT_EN
  // Prefetch into DO whenever it is empty or being popped; occupancy counts RAM words only
  always_comb begin
    w_pop       = RDEN & ~r_empty & ~w_busy;
    w_ram_rd    = (r_occ != '0) & (r_empty | w_pop) & ~w_busy;
    w_empty_nxt = ~(w_ram_rd | (~r_empty & ~w_pop));
  end
`else
  // Standard mode: a RAM read is exactly an accepted RDEN; emptiness follows occupancy
  always_comb begin
    w_pop       = RDEN & ~r_empty & ~w_busy;
    w_ram_rd    = w_pop;
    w_empty_nxt = (w_occ_nxt == '0);
  end
`endif

  // Occupancy update: simultaneous write and RAM read cancel out
  always_comb begin
    w_occ_nxt = r_occ;
    case ({w_wr, w_ram_rd})
      2'b10:   w_occ_nxt = r_occ + (ADDR_W+1)'(1);
      2'b01:   w_occ_nxt = r_occ - (ADDR_W+1)'(1);
      default: w_occ_nxt = r_occ;
    endcase
  end

  // Pointers, occupancy and registered flags all move on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
    end else begin
      if (w_wr)     r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      if (w_ram_rd) r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      r_occ   <= w_occ_nxt;
      r_empty <= w_empty_nxt;
      r_full  <= (w_occ_nxt == LP_FULL_OCC);
    end
  end

  sc_fifo_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (w_wr),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (DI),
    .i_rd_en   (w_ram_rd),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (DO)
  );

  assign EMPTY   = r_empty;
  assign FULL    = r_full;
  assign RDCOUNT = r_rd_ptr;
  assign WRCOUNT = r_wr_ptr;

endmodule
